// File: rtl/display_unit.sv
// Binary-to-BCD display driver: sequential double-dabble conversion feeding a
// multiplexed active-low 7-segment display. Define SIGNED_DISPLAY_EN for two's complement input.
module display_unit #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  displayWrite,
  input  logic [WIDTH-1:0]      dataIn,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);
  localparam logic [6:0] SegBlank = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]   scratch_q, scratch_d, adjusted;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [WIDTH-1:0]  magnitude;

  logic [PreW-1:0]   presc_q, presc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   msd;
  logic [3:0]        nib;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

`ifdef SIGNED_DISPLAY_EN
  logic sign_q, neg_q;

  // Sign is latched at capture and only published when the result commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && displayWrite) sign_q <= dataIn[WIDTH-1];
      if (state_q == StDone) neg_q <= sign_q;
    end
  end

  assign magnitude = dataIn[WIDTH-1] ? (~dataIn + 1'b1) : dataIn;
  assign negative  = neg_q;
`else
  assign magnitude = dataIn;
  assign negative  = 1'b0;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SegBlank;
    endcase
    return g;
  endfunction

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (displayWrite) begin
          shift_d   = magnitude;
          scratch_d = '0;
          cnt_d     = CntW'(WIDTH);
          state_d   = StShift;
        end
      end
      StShift: begin
        scratch_d = {adjusted[BcdW-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = scratch_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign bcd  = bcd_q;

  // Free-running scan, independent of the conversion FSM.
  always_comb begin
    idx_d   = idx_q;
    presc_d = presc_q + 1'b1;
    if (presc_q == PreMax) begin
      presc_d = '0;
      idx_d   = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Digits above the most significant nonzero nibble are blanked; digit 0 never is.
  always_comb begin
    msd  = '0;
    nib  = '0;
    an_d = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = IdxW'(i);
      if (IdxW'(i) == idx_d) begin
        nib     = bcd_q[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end
    seg_d = (idx_d > msd) ? SegBlank : glyph(nib);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b1000000;
      an_q    <= ~DIGITS'(1);
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_display_unit.sv
// Scoreboard bench for display_unit: random and directed conversions checked against a
// decimal reference model, plus continuous scan/segment checking.
module tb_display_unit;

  localparam int WIDTH    = 16;
  localparam int DIGITS   = 5;
  localparam int SCAN_DIV = 4;
  localparam int BUSY_CYC = WIDTH + 1;
  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              displayWrite = 1'b0;
  logic [WIDTH-1:0]  dataIn = '0;
  logic              busy;
  logic [4*DIGITS-1:0] bcd;
  logic              negative;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  display_unit #(
    .WIDTH   (WIDTH),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .displayWrite(displayWrite),
    .dataIn      (dataIn),
    .busy        (busy),
    .bcd         (bcd),
    .negative    (negative),
    .seg         (seg),
    .an          (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned mag;
    logic        neg;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned shown_mag = 0;
  logic        shown_neg = 1'b0;
  int          edges = 0;
  int          busy_cnt = 0;
  logic        busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned mag, input int idx);
    int unsigned p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && mag < p) return 7'b1111111;
    return GLYPH[(mag / p) % 10];
  endfunction

  function automatic void push_expect(input logic [WIDTH-1:0] v);
    exp_t e;
`ifdef SIGNED_DISPLAY_EN
    e.neg = v[WIDTH-1];
    e.mag = v[WIDTH-1] ? (32'd1 << WIDTH) - int'(v) : int'(v);
`else
    e.neg = 1'b0;
    e.mag = int'(v);
`endif
    exp_q.push_back(e);
  endfunction

  // Posedges since the last reset release: the scan position is a pure function of this.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) edges = 0;
    else edges++;
  end

  // Monitor: a falling busy presents a result; everything else is checked every cycle.
  initial forever begin
    logic popped;
    logic [DIGITS-1:0] exp_an;
    int idx;
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      busy_prev = 1'b0;
      busy_cnt  = 0;
      shown_mag = 0;
      shown_neg = 1'b0;
    end else begin
      popped = 1'b0;
      if (busy) busy_cnt++;
      if (busy_prev && !busy) begin
        check("busy_len", 32'(busy_cnt), 32'(BUSY_CYC));
        busy_cnt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_conversion at %0t: got bcd %0h, expected none", $time, bcd);
        end else begin
          e = exp_q.pop_front();
          shown_mag = e.mag;
          shown_neg = e.neg;
        end
        popped = 1'b1;
      end
      busy_prev = busy;
      check("bcd", 32'(bcd), 32'(to_bcd(shown_mag)));
      check("negative", 32'(negative), 32'(shown_neg));
      idx = (edges / SCAN_DIV) % DIGITS;
      exp_an = '1;
      exp_an[idx] = 1'b0;
      check("an", 32'(an), 32'(exp_an));
      // seg is registered from the committed bcd, so it trails a new result by one edge.
      if (!popped) check("seg", 32'(seg), 32'(exp_seg(shown_mag, idx)));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout at %0t: got busy 1, expected 0", $time);
  endtask

  task automatic convert(input logic [WIDTH-1:0] v);
    @(negedge clk);
    dataIn = v;
    displayWrite = 1'b1;
    push_expect(v);
    @(negedge clk);
    displayWrite = 1'b0;
    check("busy_after_capture", 32'(busy), 32'd1);
    wait_idle();
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_an", 32'(an), 32'b11110);
    check("rst_seg", 32'(seg), 32'b1000000);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);

    convert(16'd1234);
    convert(16'd65535);
    convert(16'd0);
    repeat (25) @(negedge clk);
    convert(16'd21);
    repeat (25) @(negedge clk);

    // Request raised mid-conversion and dropped before DONE must be ignored.
    @(negedge clk);
    dataIn = 16'd42;
    displayWrite = 1'b1;
    push_expect(16'd42);
    @(negedge clk);
    displayWrite = 1'b0;
    repeat (4) @(negedge clk);
    dataIn = 16'd99;
    displayWrite = 1'b1;
    repeat (5) @(negedge clk);
    displayWrite = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("no_requeue", 32'(busy), 32'd0);

    // Held-high request restarts back-to-back, taking dataIn at the next IDLE sample.
    @(negedge clk);
    dataIn = 16'd4321;
    displayWrite = 1'b1;
    push_expect(16'd4321);
    push_expect(16'd907);
    @(negedge clk);
    dataIn = 16'd907;
    wait_idle();
    @(negedge clk);
    displayWrite = 1'b0;
    check("b2b_restart", 32'(busy), 32'd1);
    wait_idle();

    for (int i = 0; i < 20; i++) convert(WIDTH'($urandom_range(0, 65535)));
    convert(16'hFFFB);
    convert(16'h8000);
    convert(16'd9);
    convert(16'd10);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    dataIn = 16'd500;
    displayWrite = 1'b1;
    push_expect(16'd500);
    @(negedge clk);
    displayWrite = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_neg", 32'(negative), 32'd0);
    check("mid_rst_an", 32'(an), 32'b11110);
    check("mid_rst_seg", 32'(seg), 32'b1000000);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    convert(16'd777);
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
